// File: rtl/div241_serial_acc.sv
// Sequential constant-divisor divider: one CHUNK-bit quotient digit per cycle, MSB first,
// with valid/ready handshakes on the dividend and on the quotient/remainder result.
module div241_serial_acc #(
    parameter int unsigned WIDTH   = 60,
    parameter int unsigned CHUNK   = 8,
    parameter int unsigned DIVISOR = 241,
    parameter int unsigned RW      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [RW-1:0]    out_r,
    output logic             busy
);

    localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int unsigned EXTW   = NCHUNK * CHUNK;
    localparam int unsigned VW     = RW + CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [EXTW-1:0]   sreg;
    logic [RW-1:0]     rem;
    logic [CW-1:0]     cnt;

    logic [VW-1:0]     v;
    logic [CHUNK-1:0]  qd;
    logic [RW-1:0]     rem_nxt;
    logic [EXTW-1:0]   sreg_nxt;

    // One long-division digit step; the dividend bits shift out the top while
    // quotient digits shift in at the bottom of the same register.
    always_comb begin
        v        = {rem, sreg[EXTW-1 -: CHUNK]};
        qd       = CHUNK'(v / VW'(DIVISOR));
        rem_nxt  = RW'(v % VW'(DIVISOR));
        sreg_nxt = (sreg << CHUNK) | EXTW'(qd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_q     <= '0;
            out_r     <= '0;
            sreg      <= '0;
            rem       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sreg     <= EXTW'(in_x);
                        rem      <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    sreg <= sreg_nxt;
                    rem  <= rem_nxt;
                    cnt  <= CW'(cnt + 1'b1);
                    if (cnt == CW'(NCHUNK - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_q     <= sreg_nxt[WIDTH-1:0];
                        out_r     <= rem_nxt;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Partial remainder must always be a valid residue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (32'(rem) < DIVISOR);
        end
    end

endmodule

// File: tb/tb_div241_serial_acc.sv
// Self-checking bench for div241_serial_acc: directed vectors, backpressure, mid-run reset,
// and randomized dividends against an arithmetic x/241, x%241 reference.
module tb_div241_serial_acc;

    localparam int unsigned WIDTH = 60;
    localparam int unsigned RW    = 8;
    localparam longint unsigned DIV = 241;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic [RW-1:0]    out_r;
    logic             busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    div241_serial_acc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .busy      (busy)
    );

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] q;
        logic [RW-1:0]    r;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer x, wait for accept, wait for result, hold out_ready low for 'hold' cycles, then drain.
    task automatic do_op(input logic [WIDTH-1:0] x, input int pre_gap, input int hold,
                         output logic [WIDTH-1:0] q, output logic [RW-1:0] r, output int lat);
        int n;
        bit stable;
        in_valid = 1'b0;
        repeat (pre_gap) tick();
        in_x     = x;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_x     = WIDTH'({$urandom, $urandom});
        check("busy_in_run", 64'(busy), 64'd1);
        lat = 1;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid) check("result_timeout", 64'(out_valid), 64'd1);
        q = out_q;
        r = out_r;
        stable = 1'b1;
        repeat (hold) begin
            tick();
            if (out_q !== q || out_r !== r || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0) check("hold_stable", 64'(stable), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_to_idle", 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        logic [WIDTH-1:0] q, x, x2, qb;
        logic [RW-1:0]    r, rb;
        int               lat, n;
        bit               stable, saw_valid;
        longint unsigned  xl;

        vecs[0] = '{x: 60'd0,         q: 60'd0,                r: 8'd0};
        vecs[1] = '{x: 60'd240,       q: 60'd0,                r: 8'd240};
        vecs[2] = '{x: 60'd241,       q: 60'd1,                r: 8'd0};
        vecs[3] = '{x: 60'd58081,     q: 60'd241,              r: 8'd0};
        vecs[4] = '{x: {60{1'b1}},    q: 60'd4783906658119696, r: 8'd239};
        vecs[5] = '{x: 60'd1000,      q: 60'd4,                r: 8'd36};
        vecs[6] = '{x: 60'd123456789, q: 60'd512268,           r: 8'd201};
        vecs[7] = '{x: 60'd482,       q: 60'd2,                r: 8'd0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = '0;
        repeat (3) tick();
        check("reset_outputs", 64'({in_ready, out_valid, busy}), 64'b100);
        check("reset_q", 64'(out_q), 64'd0);
        check("reset_r", 64'(out_r), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].x, 0, 0, q, r, lat);
            check($sformatf("vec%0d_q", i), 64'(q), 64'(vecs[i].q));
            check($sformatf("vec%0d_r", i), 64'(r), 64'(vecs[i].r));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
        end

        // Backpressure: result held 20 cycles while a second dividend is offered and ignored.
        in_x     = 60'd58081;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        tick();
        in_x = 60'd500;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check("bp_valid", 64'(out_valid), 64'd1);
        qb = out_q;
        rb = out_r;
        check("bp_q", 64'(qb), 64'd241);
        check("bp_r", 64'(rb), 64'd0);
        stable = 1'b1;
        repeat (20) begin
            tick();
            if (out_q !== qb || out_r !== rb || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        check("bp_stable_20", 64'(stable), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_idle", 64'({out_valid, in_ready}), 64'b01);
        tick();
        in_valid = 1'b0;
        check("bp_second_accepted", 64'({busy, in_ready}), 64'b10);
        lat = 1;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        check("bp_second_latency", 64'(lat), 64'd9);
        check("bp_second_q", 64'(out_q), 64'd2);
        check("bp_second_r", 64'(out_r), 64'd18);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during the 4th RUN cycle abandons the operation.
        in_x     = 60'd123456789;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_reset_ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
        check("midrun_reset_q", 64'(out_q), 64'd0);
        check("midrun_reset_r", 64'(out_r), 64'd0);
        saw_valid = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        check("midrun_no_valid", 64'(saw_valid), 64'd0);
        do_op(60'd1000, 0, 0, q, r, lat);
        check("after_reset_q", 64'(q), 64'd4);
        check("after_reset_r", 64'(r), 64'd36);

        // Randomized dividends with random producer/consumer gaps.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) x = WIDTH'($urandom_range(0, 100000));
            else                           x = WIDTH'({$urandom, $urandom});
            x2 = x;
            do_op(x2, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), q, r, lat);
            xl = 64'(x2);
            check($sformatf("rand%0d_q x=%0d", i, x2), 64'(q), xl / DIV);
            check($sformatf("rand%0d_r x=%0d", i, x2), 64'(r), xl % DIV);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
